// File: rtl/fmps_pkg.sv
// Shared definitions for the FMPS link collector: status codes, FSM states
// and the link-index width helper.
// Latency: n/a (declarations only).   Backpressure: n/a.
package fmps_pkg;

    localparam logic [1:0] ST_SUCCESS = 2'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } fmps_state_e;

    // Width of a field that names one of n links; never narrower than 1 bit.
    function automatic int link_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fmps_popcount.sv
// Population counter: count_o = number of set bits in bits_i.
// Latency: combinational.   Backpressure: none.
// Ports: bits_i (WIDTH) in, count_o (CW) out.
module fmps_popcount #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CW-1:0]    count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/fmps_link_collector.sv
// Gathers per-node FMPS status events from LINK_COUNT links for one FA cycle
// and publishes rx/enabled bitmaps, counts, elapsed time and a sequence number.
// Latency: events -> rxCount 1 clk, -> readoutValid 2 clk; lookup 1 clk. No backpressure: events outside ACTIVE are dropped.
// Ports: sysClk/sysResetN (async active-low); faStrobe starts a cycle; link* are
// the per-link event streams; rxBitmap/enableBitmap hold the previous cycle;
// readAddress -> readLink/readHit is a registered first-link lookup.
// Optional FMPS_COLLECTOR_LINK_STATS_EN adds statsLink/statsErrors per-link error counters.
module fmps_link_collector
    import fmps_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int INDEX_WIDTH = 5,
    parameter int LINK_COUNT  = 2,
    parameter int TIMER_WIDTH = 8,
    parameter int SEQNO_WIDTH = 3
) (
    input  logic                              sysClk,
    input  logic                              sysResetN,
    input  logic                              faStrobe,
    input  logic [INDEX_WIDTH:0]              expectedCount,
    input  logic [TIMER_WIDTH-1:0]            timeoutUs,
    input  logic [LINK_COUNT-1:0]             linkValid,
    input  logic [LINK_COUNT*INDEX_WIDTH-1:0] linkIndex,
    input  logic [LINK_COUNT*2-1:0]           linkStatus,
    input  logic [LINK_COUNT-1:0]             linkEnabled,
`ifdef FMPS_COLLECTOR_LINK_STATS_EN
    input  logic [link_w(LINK_COUNT)-1:0]     statsLink,
    output logic [15:0]                       statsErrors,
`endif
    output logic [(1<<INDEX_WIDTH)-1:0]       rxBitmap,
    output logic [(1<<INDEX_WIDTH)-1:0]       enableBitmap,
    output logic [INDEX_WIDTH:0]              rxCount,
    output logic                              readoutActive,
    output logic                              readoutValid,
    output logic                              allEnabled,
    output logic                              timeoutStrobe,
    output logic [TIMER_WIDTH-1:0]            readoutTime,
    output logic [SEQNO_WIDTH-1:0]            seqno,
    input  logic [INDEX_WIDTH-1:0]            readAddress,
    output logic [link_w(LINK_COUNT)-1:0]     readLink,
    output logic                              readHit
);

    localparam int NODES = 1 << INDEX_WIDTH;
    localparam int LW    = link_w(LINK_COUNT);
    localparam int CW    = INDEX_WIDTH + 1;
    localparam logic [31:0] PRESC_FULL = 32'(SYSCLK_RATE / 1000000 - 1);
    // First tick comes after half a microsecond so the timer rounds to nearest.
    localparam logic [31:0] PRESC_HALF = 32'(SYSCLK_RATE / 2000000 - 1);

    fmps_state_e            state_q, state_d;
    logic [NODES-1:0]       rx_work_q, rx_work_d, en_work_q, en_work_d;
    logic [NODES-1:0]       rx_bitmap_q, rx_bitmap_d, en_bitmap_q, en_bitmap_d;
    logic [CW-1:0]          rx_count_q, rx_count_d, en_count_q, en_count_d;
    logic                   readout_valid_q, readout_valid_d;
    logic                   all_enabled_q, all_enabled_d;
    logic                   timeout_strobe_q, timeout_strobe_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d, readout_time_q, readout_time_d;
    logic [SEQNO_WIDTH-1:0] seqno_q, seqno_d;
    logic [31:0]            presc_q, presc_d;
    logic [LW-1:0]          link_tab_q [NODES];
    logic [LW-1:0]          link_tab_d [NODES];
    logic [LW-1:0]          read_link_q, read_link_d;
    logic                   read_hit_q, read_hit_d;

    logic [NODES-1:0]       rx_mask, en_mask, rx_new, en_new;
    logic [LW-1:0]          first_link [NODES];
    logic [CW-1:0]          rx_new_cnt, en_new_cnt;
    logic [TIMER_WIDTH-1:0] timeout_lim;

    assign timeout_lim = (timeoutUs == '0) ? '1 : timeoutUs;

    // Links are scanned high to low so the lowest-numbered carrier of a node
    // is the last writer of first_link.
    always_comb begin
        rx_mask = '0;
        en_mask = '0;
        for (int n = 0; n < NODES; n++) first_link[n] = '0;
        for (int l = LINK_COUNT - 1; l >= 0; l--) begin
            if (linkValid[l] && (linkStatus[2*l +: 2] == ST_SUCCESS)) begin
                rx_mask[linkIndex[INDEX_WIDTH*l +: INDEX_WIDTH]] = 1'b1;
                if (linkEnabled[l]) en_mask[linkIndex[INDEX_WIDTH*l +: INDEX_WIDTH]] = 1'b1;
                first_link[linkIndex[INDEX_WIDTH*l +: INDEX_WIDTH]] = LW'(l);
            end
        end
    end

    // Only nodes not already seen this cycle contribute to the counts.
    assign rx_new = rx_mask & ~rx_work_q;
    assign en_new = en_mask & ~en_work_q;

    fmps_popcount #(.WIDTH(NODES), .CW(CW)) u_rx_pop (.bits_i(rx_new), .count_o(rx_new_cnt));
    fmps_popcount #(.WIDTH(NODES), .CW(CW)) u_en_pop (.bits_i(en_new), .count_o(en_new_cnt));

    always_comb begin
        state_d          = state_q;
        rx_work_d        = rx_work_q;
        en_work_d        = en_work_q;
        rx_bitmap_d      = rx_bitmap_q;
        en_bitmap_d      = en_bitmap_q;
        rx_count_d       = rx_count_q;
        en_count_d       = en_count_q;
        readout_valid_d  = readout_valid_q;
        all_enabled_d    = all_enabled_q;
        timeout_strobe_d = 1'b0;
        timer_d          = timer_q;
        readout_time_d   = readout_time_q;
        seqno_d          = seqno_q;
        presc_d          = presc_q;
        link_tab_d       = link_tab_q;
        read_link_d      = link_tab_q[readAddress];
        read_hit_d       = rx_work_q[readAddress];

        if (faStrobe) begin
            // Coincident link events are intentionally dropped here.
            rx_bitmap_d     = rx_work_q;
            en_bitmap_d     = en_work_q;
            rx_work_d       = '0;
            en_work_d       = '0;
            rx_count_d      = '0;
            en_count_d      = '0;
            readout_valid_d = 1'b0;
            all_enabled_d   = 1'b0;
            presc_d         = PRESC_HALF;
            timer_d         = '0;
            state_d         = S_ACTIVE;
        end else if (state_q == S_ACTIVE) begin
            rx_work_d  = rx_work_q | rx_mask;
            en_work_d  = en_work_q | en_mask;
            rx_count_d = rx_count_q + rx_new_cnt;
            en_count_d = en_count_q + en_new_cnt;
            for (int n = 0; n < NODES; n++) begin
                if (rx_new[n]) link_tab_d[n] = first_link[n];
            end

            if (presc_q == 32'd0) begin
                presc_d = PRESC_FULL;
                if (timer_q != '1) timer_d = timer_q + 1'b1;
            end else begin
                presc_d = presc_q - 32'd1;
            end

            // Completion is checked first so it wins over a coincident timeout.
            if (rx_count_q == expectedCount) begin
                state_d         = S_DONE;
                seqno_d         = seqno_q + 1'b1;
                readout_valid_d = 1'b1;
                all_enabled_d   = (en_count_q == expectedCount);
                readout_time_d  = timer_q;
            end else if (timer_q == timeout_lim) begin
                state_d          = S_TIMEOUT;
                timeout_strobe_d = 1'b1;
                all_enabled_d    = 1'b0;
                readout_time_d   = timer_q;
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            state_q          <= S_IDLE;
            rx_work_q        <= '0;
            en_work_q        <= '0;
            rx_bitmap_q      <= '0;
            en_bitmap_q      <= '0;
            rx_count_q       <= '0;
            en_count_q       <= '0;
            readout_valid_q  <= 1'b0;
            all_enabled_q    <= 1'b0;
            timeout_strobe_q <= 1'b0;
            timer_q          <= '0;
            readout_time_q   <= '0;
            seqno_q          <= '0;
            presc_q          <= '0;
            for (int n = 0; n < NODES; n++) link_tab_q[n] <= '0;
            read_link_q      <= '0;
            read_hit_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            rx_work_q        <= rx_work_d;
            en_work_q        <= en_work_d;
            rx_bitmap_q      <= rx_bitmap_d;
            en_bitmap_q      <= en_bitmap_d;
            rx_count_q       <= rx_count_d;
            en_count_q       <= en_count_d;
            readout_valid_q  <= readout_valid_d;
            all_enabled_q    <= all_enabled_d;
            timeout_strobe_q <= timeout_strobe_d;
            timer_q          <= timer_d;
            readout_time_q   <= readout_time_d;
            seqno_q          <= seqno_d;
            presc_q          <= presc_d;
            link_tab_q       <= link_tab_d;
            read_link_q      <= read_link_d;
            read_hit_q       <= read_hit_d;
        end
    end

    assign rxBitmap      = rx_bitmap_q;
    assign enableBitmap  = en_bitmap_q;
    assign rxCount       = rx_count_q;
    assign readoutActive = (state_q == S_ACTIVE);
    assign readoutValid  = readout_valid_q;
    assign allEnabled    = all_enabled_q;
    assign timeoutStrobe = timeout_strobe_q;
    assign readoutTime   = readout_time_q;
    assign seqno         = seqno_q;
    assign readLink      = read_link_q;
    assign readHit       = read_hit_q;

`ifdef FMPS_COLLECTOR_LINK_STATS_EN
    logic [15:0] err_cnt_q [LINK_COUNT];
    logic [15:0] err_cnt_d [LINK_COUNT];
    logic [15:0] stats_errors_q, stats_errors_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        for (int l = 0; l < LINK_COUNT; l++) begin
            if ((state_q == S_ACTIVE) && !faStrobe && linkValid[l] &&
                (linkStatus[2*l +: 2] != ST_SUCCESS) && (err_cnt_q[l] != 16'hFFFF)) begin
                err_cnt_d[l] = err_cnt_q[l] + 16'd1;
            end
        end
        stats_errors_d = '0;
        if (int'(statsLink) < LINK_COUNT) stats_errors_d = err_cnt_q[statsLink];
    end

    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            for (int l = 0; l < LINK_COUNT; l++) err_cnt_q[l] <= '0;
            stats_errors_q <= '0;
        end else begin
            err_cnt_q      <= err_cnt_d;
            stats_errors_q <= stats_errors_d;
        end
    end

    assign statsErrors = stats_errors_q;
`endif

endmodule

// File: tb/tb_fmps_link_collector.sv
module tb_fmps_link_collector;

    logic        sysClk = 1'b0;
    logic        sysResetN = 1'b0;
    logic        faStrobe = 1'b0;
    logic [5:0]  expectedCount = '0;
    logic [7:0]  timeoutUs = '0;
    logic [1:0]  linkValid = '0;
    logic [9:0]  linkIndex = '0;
    logic [3:0]  linkStatus = '0;
    logic [1:0]  linkEnabled = '0;
    logic [31:0] rxBitmap, enableBitmap;
    logic [5:0]  rxCount;
    logic        readoutActive, readoutValid, allEnabled, timeoutStrobe;
    logic [7:0]  readoutTime;
    logic [2:0]  seqno;
    logic [4:0]  readAddress = '0;
    logic        readLink, readHit;
`ifdef FMPS_COLLECTOR_LINK_STATS_EN
    logic        statsLink = 1'b0;
    logic [15:0] statsErrors;
`endif

    int total = 0;
    int bad   = 0;

    always #5 sysClk = ~sysClk;

    fmps_link_collector #(
        .SYSCLK_RATE(100000000), .INDEX_WIDTH(5), .LINK_COUNT(2),
        .TIMER_WIDTH(8), .SEQNO_WIDTH(3)
    ) dut (
        .sysClk(sysClk), .sysResetN(sysResetN), .faStrobe(faStrobe),
        .expectedCount(expectedCount), .timeoutUs(timeoutUs),
        .linkValid(linkValid), .linkIndex(linkIndex), .linkStatus(linkStatus),
        .linkEnabled(linkEnabled),
`ifdef FMPS_COLLECTOR_LINK_STATS_EN
        .statsLink(statsLink), .statsErrors(statsErrors),
`endif
        .rxBitmap(rxBitmap), .enableBitmap(enableBitmap), .rxCount(rxCount),
        .readoutActive(readoutActive), .readoutValid(readoutValid),
        .allEnabled(allEnabled), .timeoutStrobe(timeoutStrobe),
        .readoutTime(readoutTime), .seqno(seqno), .readAddress(readAddress),
        .readLink(readLink), .readHit(readHit)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change at negedge, DUT samples at posedge, outputs checked at the next negedge.
    task automatic tick();
        @(posedge sysClk);
        @(negedge sysClk);
    endtask

    task automatic drive(input logic [1:0] lv, input logic [4:0] i0, input logic [4:0] i1,
                         input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] en);
        linkValid   = lv;
        linkIndex   = {i1, i0};
        linkStatus  = {s1, s0};
        linkEnabled = en;
    endtask

    task automatic idle_links();
        drive(2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 2'b00);
    endtask

    task automatic fa_pulse();
        faStrobe = 1'b1;
        tick();
        faStrobe = 1'b0;
    endtask

    typedef struct {
        logic [1:0] lv;
        logic [4:0] i0;
        logic [4:0] i1;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [1:0] en;
        logic [5:0] exp_cnt;
        logic       exp_valid;
    } vec_t;

    typedef struct {
        logic [4:0] addr;
        logic       link;
        logic       hit;
    } lookup_t;

    vec_t    vt [8];
    lookup_t lk [6];
    int      cyc;

    initial begin
        // Cycle stream with expectedCount=7: multi-link, duplicates, errors, invalid links.
        vt[0] = '{2'b01, 5'd0, 5'd0, 2'd0, 2'd0, 2'b11, 6'd1, 1'b0};
        vt[1] = '{2'b11, 5'd1, 5'd4, 2'd0, 2'd0, 2'b11, 6'd3, 1'b0};
        vt[2] = '{2'b11, 5'd5, 5'd5, 2'd0, 2'd0, 2'b11, 6'd4, 1'b0};
        vt[3] = '{2'b11, 5'd3, 5'd6, 2'd2, 2'd0, 2'b11, 6'd5, 1'b0};
        vt[4] = '{2'b01, 5'd0, 5'd9, 2'd0, 2'd0, 2'b11, 6'd5, 1'b0};
        vt[5] = '{2'b11, 5'd3, 5'd6, 2'd0, 2'd0, 2'b11, 6'd6, 1'b0};
        vt[6] = '{2'b10, 5'd0, 5'd2, 2'd0, 2'd0, 2'b11, 6'd7, 1'b0};
        vt[7] = '{2'b00, 5'd0, 5'd0, 2'd0, 2'd0, 2'b00, 6'd7, 1'b1};

        lk[0] = '{5'd5, 1'b0, 1'b1};
        lk[1] = '{5'd6, 1'b1, 1'b1};
        lk[2] = '{5'd4, 1'b1, 1'b1};
        lk[3] = '{5'd3, 1'b0, 1'b1};
        lk[4] = '{5'd2, 1'b1, 1'b1};
        lk[5] = '{5'd9, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_rxCount", rxCount, 0);
        check("rst_rxBitmap", rxBitmap, 0);
        check("rst_active", readoutActive, 0);
        check("rst_valid", readoutValid, 0);
        check("rst_seqno", seqno, 0);
        @(negedge sysClk);
        sysResetN = 1'b1;
        tick();
        check("idle_active", readoutActive, 0);

        // Nodes 0..3 on link 0, all enabled
        expectedCount = 6'd4;
        timeoutUs = 8'd200;
        fa_pulse();
        check("a_active", readoutActive, 1);
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 5'(k), 5'd0, 2'd0, 2'd0, 2'b01);
            tick();
        end
        idle_links();
        check("a_count_t1", rxCount, 4);
        check("a_valid_t1", readoutValid, 0);
        tick();
        check("a_valid_t2", readoutValid, 1);
        check("a_allen", allEnabled, 1);
        check("a_seqno", seqno, 1);
        check("a_active_done", readoutActive, 0);

        // Table-driven cycle
        expectedCount = 6'd7;
        fa_pulse();
        check("b_rxbm", rxBitmap, 32'h0000000F);
        check("b_enbm", enableBitmap, 32'h0000000F);
        check("b_valid_clr", readoutValid, 0);
        check("b_count_clr", rxCount, 0);
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].lv, vt[i].i0, vt[i].i1, vt[i].s0, vt[i].s1, vt[i].en);
            tick();
            check($sformatf("b_cnt[%0d]", i), rxCount, vt[i].exp_cnt);
            check($sformatf("b_valid[%0d]", i), readoutValid, vt[i].exp_valid);
        end
        idle_links();
        check("b_allen", allEnabled, 1);
        check("b_seqno", seqno, 2);
        for (int i = 0; i < 6; i++) begin
            readAddress = lk[i].addr;
            tick();
            check($sformatf("b_hit[%0d]", lk[i].addr), readHit, lk[i].hit);
            if (lk[i].hit) check($sformatf("b_link[%0d]", lk[i].addr), readLink, lk[i].link);
        end
`ifdef FMPS_COLLECTOR_LINK_STATS_EN
        statsLink = 1'b0;
        tick();
        check("b_stats0", statsErrors, 1);
        statsLink = 1'b1;
        tick();
        check("b_stats1", statsErrors, 0);
`endif

        // Node 2 received but not enabled
        expectedCount = 6'd1;
        fa_pulse();
        check("c_rxbm", rxBitmap, 32'h0000007F);
        check("c_enbm", enableBitmap, 32'h0000007F);
        drive(2'b01, 5'd2, 5'd0, 2'd0, 2'd0, 2'b00);
        tick();
        idle_links();
        tick();
        check("c_valid", readoutValid, 1);
        check("c_allen", allEnabled, 0);
        check("c_seqno", seqno, 3);

        // faStrobe coincident with an event, then a timeout cycle
        expectedCount = 6'd3;
        timeoutUs = 8'd10;
        drive(2'b01, 5'd7, 5'd0, 2'd0, 2'd0, 2'b01);
        fa_pulse();
        idle_links();
        check("d_rxbm", rxBitmap, 32'h00000004);
        check("d_enbm", enableBitmap, 32'h00000000);
        check("d_drop_cnt", rxCount, 0);
        cyc = 0;
        drive(2'b01, 5'd1, 5'd0, 2'd0, 2'd0, 2'b01);
        tick(); cyc++;
        drive(2'b01, 5'd2, 5'd0, 2'd0, 2'd0, 2'b01);
        tick(); cyc++;
        idle_links();
        check("d_cnt", rxCount, 2);
        while (!timeoutStrobe && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("d_to_seen", timeoutStrobe, 1);
        check("d_to_window", (cyc >= 940 && cyc <= 960), 1);
        check("d_time", readoutTime, 10);
        check("d_seqno", seqno, 3);
        check("d_valid", readoutValid, 0);
        check("d_allen", allEnabled, 0);
        check("d_active", readoutActive, 0);
        drive(2'b01, 5'd9, 5'd0, 2'd0, 2'd0, 2'b01);
        tick();
        idle_links();
        check("d_pulse", timeoutStrobe, 0);
        check("d_ignore", rxCount, 2);

        // expectedCount = 0 completes on the first ACTIVE cycle
        expectedCount = 6'd0;
        fa_pulse();
        check("e_active", readoutActive, 1);
        check("e_valid0", readoutValid, 0);
        tick();
        check("e_valid1", readoutValid, 1);
        check("e_seqno", seqno, 4);

        // Asynchronous reset in the middle of ACTIVE
        expectedCount = 6'd5;
        fa_pulse();
        drive(2'b11, 5'd3, 5'd8, 2'd0, 2'd1, 2'b11);
        tick();
        idle_links();
        check("f_cnt", rxCount, 1);
`ifdef FMPS_COLLECTOR_LINK_STATS_EN
        statsLink = 1'b1;
        tick();
        check("f_stats_pre", statsErrors, 1);
`endif
        #2 sysResetN = 1'b0;
        #1;
        check("f_cnt_rst", rxCount, 0);
        check("f_active_rst", readoutActive, 0);
        check("f_seqno_rst", seqno, 0);
        check("f_valid_rst", readoutValid, 0);
        check("f_allen_rst", allEnabled, 0);
        check("f_rxbm_rst", rxBitmap, 0);
        check("f_enbm_rst", enableBitmap, 0);
        check("f_time_rst", readoutTime, 0);
`ifdef FMPS_COLLECTOR_LINK_STATS_EN
        check("f_stats_rst", statsErrors, 0);
`endif
        @(negedge sysClk);
        sysResetN = 1'b1;
        tick();
        check("f_idle", readoutActive, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
